// File: rtl/vector_load_unit_if.sv
// Memory read port and register-file write port (WE3/A3/WD3/SFlag/LDSFlag) of the vector load unit.
interface vector_load_unit_if #(
    parameter int unsigned LANES = 6,
    parameter int unsigned DW    = 8,
    parameter int unsigned AW    = 10
);
    logic                  mem_re;
    logic [AW-1:0]         mem_addr;
    logic [DW-1:0]         mem_rdata;
    logic                  mem_rvalid;
    logic                  WE3;
    logic [3:0]            A3;
    logic [LANES*DW-1:0]   WD3;
    logic                  SFlag;
    logic                  LDSFlag;

    modport master (
        output mem_re, mem_addr, WE3, A3, WD3, SFlag, LDSFlag,
        input  mem_rdata, mem_rvalid
    );

    modport slave (
        input  mem_re, mem_addr, WE3, A3, WD3, SFlag, LDSFlag,
        output mem_rdata, mem_rvalid
    );
endinterface

// File: rtl/vector_load_unit.sv
// Vector/scalar load unit: fetches 6 bytes (or 1) one read at a time, then writes the regfile once.
// Optional feature macro VLD_STRIDE_EN: lane addresses advance by the stride port instead of by 1.
module vector_load_unit #(
    parameter int unsigned LANES = 6,
    parameter int unsigned DW    = 8,
    parameter int unsigned AW    = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  scalar,
    input  logic [AW-1:0]         base_addr,
    input  logic [AW-1:0]         stride,
    input  logic [3:0]            dest,
    vector_load_unit_if.master    bus,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);
    localparam int unsigned LW = $clog2(LANES);
    localparam int unsigned VW = LANES * DW;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_REQ   = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_WRITE = 2'd3;

    localparam logic [3:0]    MAX_SCALAR_DEST = 4'(LANES - 1);
    localparam logic [LW-1:0] LAST_VEC_LANE   = LW'(LANES - 1);

    logic [1:0]    state, state_n;
    logic [LW-1:0] lane, lane_n, last_lane;
    logic [AW-1:0] addr, addr_n, step;
    logic [VW-1:0] lane_buf, lane_buf_n;
    logic          scalar_q, scalar_n;
    logic [3:0]    dest_q, dest_n;

    logic          mem_re_n, we_n, sflag_n, busy_n, done_n, err_n;
    logic [AW-1:0] mem_addr_n;
    logic [3:0]    a3_n;
    logic [VW-1:0] wd3_n;

`ifdef VLD_STRIDE_EN
    logic [AW-1:0] stride_q;

    // Stride is captured with the rest of the command
    always_ff @(posedge clk) begin
        if (rst)
            stride_q <= '0;
        else if (state == S_IDLE && start)
            stride_q <= stride;
    end

    assign step = stride_q;
`else
    logic stride_unused;
    assign stride_unused = ^stride;
    assign step          = AW'(1);
`endif

    assign last_lane = scalar_q ? '0 : LAST_VEC_LANE;

    // Next-state and next-output logic; outputs are registered on entry to each state
    always_comb begin
        state_n    = state;
        lane_n     = lane;
        addr_n     = addr;
        lane_buf_n = lane_buf;
        scalar_n   = scalar_q;
        dest_n     = dest_q;
        mem_re_n   = 1'b0;
        mem_addr_n = '0;
        we_n       = 1'b0;
        a3_n       = '0;
        wd3_n      = '0;
        sflag_n    = 1'b0;
        done_n     = 1'b0;
        err_n      = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    scalar_n   = scalar;
                    dest_n     = dest;
                    lane_n     = '0;
                    addr_n     = base_addr;
                    lane_buf_n = '0;
                    if (scalar && (dest > MAX_SCALAR_DEST)) begin
                        err_n  = 1'b1;
                        done_n = 1'b1;
                    end else begin
                        state_n    = S_REQ;
                        mem_re_n   = 1'b1;
                        mem_addr_n = base_addr;
                    end
                end
            end
            S_REQ: state_n = S_WAIT;
            S_WAIT: begin
                if (bus.mem_rvalid) begin
                    for (int unsigned i = 0; i < LANES; i++) begin
                        if (LW'(i) == lane)
                            lane_buf_n[i*DW +: DW] = bus.mem_rdata;
                    end
                    if (lane == last_lane) begin
                        state_n = S_WRITE;
                        we_n    = 1'b1;
                        done_n  = 1'b1;
                        a3_n    = dest_q;
                        wd3_n   = lane_buf_n;
                        sflag_n = scalar_q;
                    end else begin
                        state_n    = S_REQ;
                        lane_n     = lane + LW'(1);
                        addr_n     = addr + step;
                        mem_re_n   = 1'b1;
                        mem_addr_n = addr + step;
                    end
                end
            end
            S_WRITE: state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase

        busy_n = (state_n != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            lane        <= '0;
            addr        <= '0;
            lane_buf    <= '0;
            scalar_q    <= 1'b0;
            dest_q      <= '0;
            bus.mem_re  <= 1'b0;
            bus.mem_addr <= '0;
            bus.WE3     <= 1'b0;
            bus.A3      <= '0;
            bus.WD3     <= '0;
            bus.SFlag   <= 1'b0;
            bus.LDSFlag <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            state       <= state_n;
            lane        <= lane_n;
            addr        <= addr_n;
            lane_buf    <= lane_buf_n;
            scalar_q    <= scalar_n;
            dest_q      <= dest_n;
            bus.mem_re  <= mem_re_n;
            bus.mem_addr <= mem_addr_n;
            bus.WE3     <= we_n;
            bus.A3      <= a3_n;
            bus.WD3     <= wd3_n;
            bus.SFlag   <= sflag_n;
            bus.LDSFlag <= sflag_n;
            busy        <= busy_n;
            done        <= done_n;
            err         <= err_n;
        end
    end
endmodule

// File: tb/tb_vector_load_unit.sv
// Scoreboard bench for vector_load_unit: random loads against a byte-array memory model.
module tb_vector_load_unit;
    localparam int unsigned LANES = 6;
    localparam int unsigned DW    = 8;
    localparam int unsigned AW    = 10;
    localparam int          MEMSZ = 1 << AW;

    typedef struct {
        bit          is_err;
        logic [3:0]  a3;
        logic [47:0] wd3;
        bit          sc;
        int          cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          scalar = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW-1:0] stride = '0;
    logic [3:0]    dest = '0;
    logic          busy, done, err;

    vector_load_unit_if #(.LANES(LANES), .DW(DW), .AW(AW)) bus ();

    vector_load_unit #(.LANES(LANES), .DW(DW), .AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .scalar    (scalar),
        .base_addr (base_addr),
        .stride    (stride),
        .dest      (dest),
        .bus       (bus.master),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    int   addr_q[$];
    logic [7:0] mem [MEMSZ];
    int   lat = 1;
    bit   inject = 1'b0;
    int   cnt = 0;
    int   paddr = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    // Memory: answers each read strobe 'lat' cycles later; pending reads vanish on reset
    initial begin
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
    end
    always @(negedge clk) begin
        if (rst) begin
            cnt = 0;
            bus.mem_rvalid = 1'b0;
        end else begin
            bus.mem_rvalid = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    bus.mem_rvalid = 1'b1;
                    bus.mem_rdata  = mem[paddr];
                end
            end
            if (inject) begin
                bus.mem_rvalid = 1'b1;
                bus.mem_rdata  = 8'h5A;
            end
            if (bus.mem_re) begin
                cnt   = lat;
                paddr = int'(bus.mem_addr);
            end
        end
    end

    // Monitor: pops expectations whenever the DUT shows a read strobe or a completion
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.mem_re) begin
                if (addr_q.size() == 0) chk("spurious_mem_re", 1, 0);
                else chk("mem_addr", 64'(bus.mem_addr), 64'(addr_q.pop_front()));
            end
            if (bus.WE3 || err) begin
                if (exp_q.size() == 0) chk("spurious_completion", 1, 0);
                else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("err", 64'(err), 64'(e.is_err));
                    chk("we3", 64'(bus.WE3), 64'(!e.is_err));
                    chk("done", 64'(done), 64'd1);
                    if (!e.is_err) begin
                        chk("A3", 64'(bus.A3), 64'(e.a3));
                        chk("WD3", 64'(bus.WD3), 64'(e.wd3));
                        chk("SFlag", 64'(bus.SFlag), 64'(e.sc));
                        chk("LDSFlag", 64'(bus.LDSFlag), 64'(e.sc));
                    end
                    if (e.cyc >= 0) chk("latency", 64'(cyc), 64'(e.cyc));
                end
            end else begin
                chk("done_without_write", 64'(done), 64'd0);
            end
            if (!bus.WE3)
                chk("write_port_idle", {bus.A3, bus.WD3, bus.SFlag, bus.LDSFlag}, 64'd0);
        end
    end

    // Reference model: lane i comes from base + i*step modulo memory size
    task automatic issue(input bit sc, input int base, input int str, input int dst);
        exp_t e;
        int   step;
        int   nl;
`ifdef VLD_STRIDE_EN
        step = str;
`else
        step = 1;
`endif
        e.is_err = sc && (dst > 5);
        e.a3     = 4'(dst);
        e.sc     = sc;
        e.wd3    = '0;
        nl       = sc ? 1 : LANES;
        if (e.is_err) e.cyc = cyc + 1;
        else if (lat == 1) e.cyc = cyc + (sc ? 3 : 13);
        else e.cyc = -1;
        if (!e.is_err) begin
            for (int i = 0; i < nl; i++) begin
                int a;
                a = (base + i * step) % MEMSZ;
                addr_q.push_back(a);
                e.wd3[i*8 +: 8] = mem[a];
            end
        end
        exp_q.push_back(e);
        scalar    = sc;
        base_addr = AW'(base);
        stride    = AW'(str);
        dest      = 4'(dst);
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        base_addr = AW'($urandom);
        stride    = AW'($urandom);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) chk("timeout_busy", 1, 0);
    endtask

    task automatic load(input bit sc, input int base, input int str, input int dst);
        issue(sc, base, str, dst);
        wait_idle();
    endtask

    initial begin
        for (int i = 0; i < MEMSZ; i++) mem[i] = 8'($urandom);
        repeat (3) @(negedge clk);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_outputs", {bus.mem_re, bus.WE3, done, err, bus.A3, bus.WD3}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Basic vector and scalar loads with single-cycle memory
        for (int i = 0; i < 6; i++) mem[16 + i] = 8'(i + 1);
        load(1'b0, 'h010, 1, 3);
        inject = 1'b1;
        @(negedge clk);
        inject = 1'b0;
        @(negedge clk);
        mem['h20] = 8'hAB;
        load(1'b1, 'h020, 0, 2);
        load(1'b1, 'h020, 0, 7);
        load(1'b1, 'h020, 0, 5);
        load(1'b0, 'h3FE, 1, 9);
        load(1'b0, 'h100, 4, 1);
        load(1'b0, 'h100, 0, 15);

        // Slow memory, ignored start while busy, reset after lane 2 is captured
        lat = 3;
        issue(1'b0, 'h050, 2, 4);
        repeat (4) @(negedge clk);
        scalar = 1'b0; dest = 4'd9; base_addr = AW'('h200); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        begin
            int n = 0;
            while (addr_q.size() > 2 && n < 200) begin
                @(negedge clk);
                n++;
            end
            if (n >= 200) chk("timeout_lane2", 1, 0);
        end
        rst = 1'b1;
        exp_q.delete();
        addr_q.delete();
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_outputs", {bus.mem_re, bus.WE3, done, err, bus.A3, bus.WD3}, 64'd0);
        repeat (6) @(negedge clk);
        lat = 1;
        load(1'b0, 'h060, 3, 6);

        // Randomized loads, issued back-to-back as soon as the unit is idle
        for (int k = 0; k < 40; k++) begin
            bit sc;
            sc  = ($urandom_range(0, 3) == 0);
            lat = $urandom_range(1, 4);
            load(sc, int'($urandom_range(0, MEMSZ - 1)), int'($urandom_range(0, 1023)),
                 sc ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 15)));
        end

        repeat (8) @(negedge clk);
        chk("queues_drained", 64'(exp_q.size() + addr_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
